// File: rtl/milano_pkg.sv
// Shared types for the milano execute-stage multiply/divide unit.
package milano_pkg;

    typedef enum logic [3:0] {
        MD_OP_NONE   = 4'd0,
        MD_OP_MUL    = 4'd1,
        MD_OP_MULH   = 4'd2,
        MD_OP_MULHSU = 4'd3,
        MD_OP_MULHU  = 4'd4,
        MD_OP_DIV    = 4'd5,
        MD_OP_DIVU   = 4'd6,
        MD_OP_REM    = 4'd7,
        MD_OP_REMU   = 4'd8
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } md_state_e;

    localparam int MD_DIV_CYCLES = 32;

    function automatic logic is_mul_op(md_op_e op);
        return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU};
    endfunction

    function automatic logic is_div_op(md_op_e op);
        return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
    endfunction

endpackage

// File: rtl/milano_divider.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per cycle.
module milano_divider
    import milano_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);

    localparam int CW = $clog2(MD_DIV_CYCLES);

    logic [CW-1:0]   cnt;
    logic            running;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic            ge;

    assign trial = {rem_q, quo_q[XLEN-1]};
    assign diff  = trial - {1'b0, dsr_q};
    // trial < 2*divisor, so a borrow out of bit XLEN means trial < divisor
    assign ge    = ~diff[XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
        end else if (kill) begin
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
            rem_q   <= '0;
            quo_q   <= dividend;
            dsr_q   <= divisor;
        end else if (running) begin
            rem_q <= ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ge};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(MD_DIV_CYCLES - 1))
                running <= 1'b0;
        end
    end

    assign done      = running && (cnt == CW'(MD_DIV_CYCLES - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/milano_mdu.sv
// RV32M multiply/divide unit: two-cycle multiplier, iterative divider, sign fix-up.
//   state  | meaning
//   S_IDLE | ready for a request
//   S_MUL  | product of latched operands formed and registered
//   S_DIV  | divider stepping, one bit per cycle
//   S_FIX  | sign correction of quotient/remainder
//   S_DONE | result_o valid, valid_o pulses
module milano_mdu
    import milano_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  md_op_e          md_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e       state;
    md_op_e          op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            valid_q;

    logic            accept;
    logic            signed_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            div_start;

    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            div_done;
    logic [XLEN-1:0] fix_res;

    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state != S_IDLE);
    assign valid_o = valid_q && !kill_i;
    assign accept  = valid_i && ready_o && !kill_i && (md_op_i != MD_OP_NONE);

    assign signed_div = (md_op_i == MD_OP_DIV) || (md_op_i == MD_OP_REM);
    assign a_neg      = signed_div && op_a_i[XLEN-1];
    assign b_neg      = signed_div && op_b_i[XLEN-1];
    assign a_mag      = a_neg ? -op_a_i : op_a_i;
    assign b_mag      = b_neg ? -op_b_i : op_b_i;
    assign div_zero   = (op_b_i == '0);
    assign div_ovf    = signed_div && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    assign special    = is_div_op(md_op_i) && (div_zero || div_ovf);
    assign div_start  = accept && is_div_op(md_op_i) && !special;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = (md_op_i inside {MD_OP_DIV, MD_OP_DIVU}) ? '1 : op_a_i;
        else if (md_op_i == MD_OP_DIV)
            special_res = op_a_i;
    end

    // 33-bit sign/zero-extended operands, widened to the full product width
    assign mul_a   = {{XLEN{(op_q inside {MD_OP_MULH, MD_OP_MULHSU}) && a_q[XLEN-1]}}, a_q};
    assign mul_b   = {{XLEN{(op_q == MD_OP_MULH) && b_q[XLEN-1]}}, b_q};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_q == MD_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = quotient;
        case (op_q)
            MD_OP_DIV:  fix_res = neg_quo_q ? -quotient : quotient;
            MD_OP_REM:  fix_res = neg_rem_q ? -remainder : remainder;
            MD_OP_REMU: fix_res = remainder;
            default:    fix_res = quotient;
        endcase
    end

    milano_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk_i),
        .rst       (rst_i),
        .start     (div_start),
        .kill      (kill_i),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (div_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            op_q      <= MD_OP_NONE;
            a_q       <= '0;
            b_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            valid_q   <= 1'b0;
            result_o  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (state != S_IDLE && kill_i) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            op_q      <= md_op_i;
                            a_q       <= op_a_i;
                            b_q       <= op_b_i;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            if (special) begin
                                result_o <= special_res;
                                valid_q  <= 1'b1;
                                state    <= S_DONE;
                            end else if (is_mul_op(md_op_i)) begin
                                state <= S_MUL;
                            end else begin
                                state <= S_DIV;
                            end
                        end
                    end
                    S_MUL: begin
                        result_o <= mul_res;
                        valid_q  <= 1'b1;
                        state    <= S_DONE;
                    end
                    S_DIV: begin
                        if (div_done)
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        result_o <= fix_res;
                        valid_q  <= 1'b1;
                        state    <= S_DONE;
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
